// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with registered or first-word-fall-through read,
// fill level, almost-full/empty thresholds, sticky overflow/underflow flags and flush.
module sync_fifo_flex #(
    parameter int DATASIZE     = 8,
    parameter int ADDRSIZE     = 4,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = 14,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                write_enable,
    input  logic [DATASIZE-1:0] write_data,
    input  logic                read_enable,
    output logic [DATASIZE-1:0] read_data,
    output logic                read_valid,
    output logic                write_full,
    output logic                read_empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDRSIZE:0]   fill_count,
    output logic                overflow,
    output logic                underflow
);
    localparam int CW = ADDRSIZE + 1;
    localparam logic [CW-1:0] DEPTH  = CW'(1 << ADDRSIZE);
    localparam logic [CW-1:0] AF_LVL = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AE_LVL = CW'(AEMPTY_LEVEL);

    logic [DATASIZE-1:0] mem [1 << ADDRSIZE];
    logic [CW-1:0]       waddr, raddr, count_next;
    logic                push_ok, pop_ok;

    // Accept decisions use the registered flags, so a write while full is dropped even with a pop.
    always_comb begin
        push_ok    = write_enable & ~write_full;
        pop_ok     = read_enable & ~read_empty;
        count_next = flush ? '0 : fill_count + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk)
        if (push_ok & ~flush) mem[waddr[ADDRSIZE-1:0]] <= write_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            waddr        <= '0;
            raddr        <= '0;
            fill_count   <= '0;
            write_full   <= 1'b0;
            read_empty   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            waddr        <= flush ? '0 : waddr + CW'(push_ok);
            raddr        <= flush ? '0 : raddr + CW'(pop_ok);
            fill_count   <= count_next;
            write_full   <= count_next == DEPTH;
            read_empty   <= count_next == '0;
            almost_full  <= count_next >= AF_LVL;
            almost_empty <= count_next <= AE_LVL;
            overflow     <= ~flush & (overflow | (write_enable & write_full));
            underflow    <= ~flush & (underflow | (read_enable & read_empty));
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign read_valid = ~read_empty;
        assign read_data  = read_empty ? '0 : mem[raddr[ADDRSIZE-1:0]];
    end else begin : g_reg
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                read_data  <= '0;
                read_valid <= 1'b0;
            end else begin
                read_valid <= pop_ok & ~flush;
                if (pop_ok & ~flush) read_data <= mem[raddr[ADDRSIZE-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives a registered-read and an FWFT instance with identical stimulus
// and compares both against a queue-based reference model.
module tb_sync_fifo_flex;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0, write_enable = 1'b0, read_enable = 1'b0;
    logic [7:0] write_data = '0;

    logic [7:0] rd0, rd1;
    logic [4:0] fc0, fc1;
    logic       rv0, wf0, re0, af0, ae0, ov0, un0;
    logic       rv1, wf1, re1, af1, ae1, ov1, un1;

    int checks = 0, errors = 0;

    logic [7:0] q[$];
    logic       ov_m = 1'b0, un_m = 1'b0, rv_m = 1'b0;
    logic [7:0] rd_m = '0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.FWFT(0)) u_reg (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write_enable(write_enable),
        .write_data(write_data), .read_enable(read_enable), .read_data(rd0), .read_valid(rv0),
        .write_full(wf0), .read_empty(re0), .almost_full(af0), .almost_empty(ae0),
        .fill_count(fc0), .overflow(ov0), .underflow(un0)
    );

    sync_fifo_flex #(.FWFT(1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .flush(flush), .write_enable(write_enable),
        .write_data(write_data), .read_enable(read_enable), .read_data(rd1), .read_valid(rv1),
        .write_full(wf1), .read_empty(re1), .almost_full(af1), .almost_empty(ae1),
        .fill_count(fc1), .overflow(ov1), .underflow(un1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("fill0", 32'(fc0), n);
        check("full0", 32'(wf0), 32'(n == 16));
        check("empty0", 32'(re0), 32'(n == 0));
        check("afull0", 32'(af0), 32'(n >= 14));
        check("aempty0", 32'(ae0), 32'(n <= 2));
        check("ovf0", 32'(ov0), 32'(ov_m));
        check("unf0", 32'(un0), 32'(un_m));
        check("rvalid0", 32'(rv0), 32'(rv_m));
        check("rdata0", 32'(rd0), 32'(rd_m));
        check("fill1", 32'(fc1), n);
        check("full1", 32'(wf1), 32'(n == 16));
        check("empty1", 32'(re1), 32'(n == 0));
        check("afull1", 32'(af1), 32'(n >= 14));
        check("aempty1", 32'(ae1), 32'(n <= 2));
        check("ovf1", 32'(ov1), 32'(ov_m));
        check("unf1", 32'(un1), 32'(un_m));
        check("rvalid1", 32'(rv1), 32'(n > 0));
        if (n > 0) check("rdata1", 32'(rd1), 32'(q[0]));
    endtask

    task automatic model_reset();
        q.delete();
        ov_m = 1'b0;
        un_m = 1'b0;
        rv_m = 1'b0;
        rd_m = '0;
    endtask

    // One clock cycle: apply inputs, advance the model from pre-edge state, check after the edge.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic fl);
        logic full, empty;
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        flush        = fl;
        full  = q.size() == 16;
        empty = q.size() == 0;
        if (fl) begin
            q.delete();
            ov_m = 1'b0;
            un_m = 1'b0;
            rv_m = 1'b0;
        end else begin
            if (we && full) ov_m = 1'b1;
            if (re && empty) un_m = 1'b1;
            rv_m = re && !empty;
            if (rv_m) rd_m = q.pop_front();
            if (we && !full) q.push_back(wd);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        flush        = 1'b0;
        reset_n      = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #12;
        apply_reset();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
        for (int i = 0; i < 13; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        #2;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            logic we, re, fl;
            we = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            re = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl = $urandom_range(0, 63) == 0;
            cycle(we, 8'($urandom), re, fl);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
